// File: rtl/proc_run_pkg.sv
// Shared types and helpers for the PROCESADOR run controller.
package proc_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DONE,
        FAULT
    } run_state_e;

    // Window check is done at 33 bits so base+words cannot wrap the upper bound.
    function automatic logic in_out_window(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] words);
        logic [32:0] lim;
        lim = {1'b0, base} + {1'b0, words};
        return (addr >= base) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/run_counter.sv
// Clearable, enabled up-counter that saturates at MAX and flags when it sits at TERM.
module run_counter #(
    parameter int unsigned W    = 8,
    parameter int unsigned MAX  = 255,
    parameter int unsigned TERM = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         term
);

    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] TERM_V = W'(TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != MAX_V)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign term = (cnt == TERM_V);

endmodule

// File: rtl/proc_run_ctrl.sv
// Run controller: sequences core reset on start, counts RUN cycles and output
// writes, and reports completion (halt or full image) or timeout.
module proc_run_ctrl
    import proc_run_pkg::*;
#(
    parameter int unsigned       RST_HOLD   = 4,
    parameter int unsigned       CNT_W      = 32,
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] OUT_BASE   = 16'h4000,
    parameter int unsigned       OUT_WORDS  = 1024,
    parameter int unsigned       TIMEOUT    = 1_000_000,
    parameter logic [31:0]       HALT_INSTR = 32'hFFFF_FFFF,
    parameter int unsigned       PROG_STEP  = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [31:0]                        instr,
    input  logic                               dm_we,
    input  logic [ADDR_W-1:0]                  dm_addr,
    output logic                               core_rst,
    output logic                               running,
    output logic                               done,
    output logic                               timeout_err,
    output logic [CNT_W-1:0]                   cycles,
    output logic [$clog2(OUT_WORDS+1)-1:0]     pixels,
    output logic                               progress_tick
);

    localparam int unsigned PIX_W  = $clog2(OUT_WORDS + 1);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned STEP_W = $clog2(PROG_STEP + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PROG_STEP - 1);

    run_state_e state, state_nx;

    logic              launch, in_run, qwrite, halt_hit, done_cond, tmo;
    logic              hold_term, cyc_term, pix_term;
    logic [HOLD_W-1:0] hold_cnt_unused;
    logic [STEP_W-1:0] step_cnt;
    logic              core_rst_nx, running_nx, done_nx, timeout_err_nx;

    assign launch    = start && ((state == IDLE) || (state == DONE) || (state == FAULT));
    assign in_run    = (state == RUN);
    assign qwrite    = in_run && dm_we &&
                       in_out_window(32'(dm_addr), 32'(OUT_BASE), 32'(OUT_WORDS));
    assign halt_hit  = in_run && (instr == HALT_INSTR);
    assign done_cond = halt_hit || (qwrite && pix_term);
    assign tmo       = in_run && cyc_term;

    run_counter #(.W(HOLD_W), .MAX(RST_HOLD), .TERM(RST_HOLD)) u_hold (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch),
        .en   (state == HOLD),
        .cnt  (hold_cnt_unused),
        .term (hold_term)
    );

    // Counts on the exit edge too, so the reported total includes the deciding cycle.
    run_counter #(.W(CNT_W), .MAX(TIMEOUT), .TERM(TIMEOUT - 1)) u_cycles (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch),
        .en   (in_run),
        .cnt  (cycles),
        .term (cyc_term)
    );

    run_counter #(.W(PIX_W), .MAX(OUT_WORDS), .TERM(OUT_WORDS - 1)) u_pixels (
        .clk  (clk),
        .rst  (rst),
        .clr  (launch),
        .en   (qwrite),
        .cnt  (pixels),
        .term (pix_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            core_rst    <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            core_rst    <= core_rst_nx;
            running     <= running_nx;
            done        <= done_nx;
            timeout_err <= timeout_err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, FAULT: if (start) state_nx = HOLD;
            HOLD:              if (hold_term) state_nx = RUN;
            RUN: begin
                if (done_cond)  state_nx = DONE;
                else if (tmo)   state_nx = FAULT;
            end
            default:           state_nx = IDLE;
        endcase
    end

    // Decoded from the next state so the flag registers line up with the state register.
    always_comb begin
        core_rst_nx    = 1'b1;
        running_nx     = 1'b0;
        done_nx        = 1'b0;
        timeout_err_nx = 1'b0;
        unique case (state_nx)
            RUN: begin
                core_rst_nx = 1'b0;
                running_nx  = 1'b1;
            end
            DONE:    done_nx        = 1'b1;
            FAULT:   timeout_err_nx = 1'b1;
            default: ;
        endcase
    end

    // Modulo-PROG_STEP write counter; only qualifying RUN writes advance it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt      <= '0;
            progress_tick <= 1'b0;
        end else begin
            progress_tick <= qwrite && (step_cnt == STEP_LAST);
            if (launch) begin
                step_cnt <= '0;
            end else if (qwrite) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl: vector table for a full write-driven run,
// plus hand sequences for halt, timeout, tie and asynchronous reset.
module tb_proc_run_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, start, dm_we;
    logic [31:0] instr;
    logic [15:0] dm_addr;
    logic        core_rst, running, done, timeout_err, progress_tick;
    logic [31:0] cycles;
    logic [3:0]  pixels;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    proc_run_ctrl #(
        .RST_HOLD  (4),
        .CNT_W     (32),
        .ADDR_W    (16),
        .OUT_BASE  (16'h4000),
        .OUT_WORDS (12),
        .TIMEOUT   (50),
        .HALT_INSTR(32'hFFFF_FFFF),
        .PROG_STEP (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .instr        (instr),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .core_rst     (core_rst),
        .running      (running),
        .done         (done),
        .timeout_err  (timeout_err),
        .cycles       (cycles),
        .pixels       (pixels),
        .progress_tick(progress_tick)
    );

    typedef struct {
        logic        st;
        logic [31:0] ins;
        logic        we;
        logic [15:0] ad;
        logic        e_crst;
        logic        e_run;
        logic        e_done;
        logic        e_terr;
        logic [31:0] e_cyc;
        logic [3:0]  e_pix;
        logic        e_tick;
    } vec_t;

    vec_t tv[23];

    function automatic vec_t mk(input logic st, input logic [31:0] ins, input logic we,
                                input logic [15:0] ad, input logic cr, input logic rn,
                                input logic dn, input logic te, input logic [31:0] cy,
                                input logic [3:0] px, input logic tk);
        vec_t v;
        v.st = st; v.ins = ins; v.we = we; v.ad = ad;
        v.e_crst = cr; v.e_run = rn; v.e_done = dn; v.e_terr = te;
        v.e_cyc = cy; v.e_pix = px; v.e_tick = tk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic cr, input logic rn, input logic dn,
                           input logic te, input logic [31:0] cy, input logic [3:0] px,
                           input logic tk);
        chk($sformatf("%s.core_rst", tag),    32'(core_rst),      32'(cr));
        chk($sformatf("%s.running", tag),     32'(running),       32'(rn));
        chk($sformatf("%s.done", tag),        32'(done),          32'(dn));
        chk($sformatf("%s.timeout_err", tag), 32'(timeout_err),   32'(te));
        chk($sformatf("%s.cycles", tag),      cycles,             cy);
        chk($sformatf("%s.pixels", tag),      32'(pixels),        32'(px));
        chk($sformatf("%s.tick", tag),        32'(progress_tick), 32'(tk));
    endtask

    task automatic step(input logic s, input logic [31:0] ins, input logic we,
                        input logic [15:0] ad);
        start = s; instr = ins; dm_we = we; dm_addr = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, NOP, 1'b0, 16'h0000);
    endtask

    task automatic do_start(input string tag);
        step(1'b1, NOP, 1'b0, 16'h0000);
        chk_all({tag, ".launch"}, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk($sformatf("%s.hold%0d.core_rst", tag, i), 32'(core_rst), 32'd1);
            chk($sformatf("%s.hold%0d.running", tag, i),  32'(running),  32'd0);
        end
        idle();
        chk_all({tag, ".run0"}, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic run_until(input string tag, input logic [31:0] target);
        int unsigned n;
        n = 0;
        while ((cycles != target) && (n < 200)) begin
            idle();
            n++;
        end
        chk({tag, ".reach"}, cycles, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ticks;

        // Reset-state checks happen before any clock edge, so they prove asynchrony.
        rst = 1'b1; start = 1'b0; instr = NOP; dm_we = 1'b0; dm_addr = 16'h0000;
        #2;
        chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        chk_all("idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);

        // Window is 0x4000..0x400B; start and halt during HOLD must be ignored.
        tv[0]  = mk(1'b1, NOP,  1'b0, 16'h0000, 1, 0, 0, 0,  0,  0, 0);
        tv[1]  = mk(1'b0, NOP,  1'b0, 16'h0000, 1, 0, 0, 0,  0,  0, 0);
        tv[2]  = mk(1'b1, NOP,  1'b0, 16'h0000, 1, 0, 0, 0,  0,  0, 0);
        tv[3]  = mk(1'b0, HALT, 1'b0, 16'h0000, 1, 0, 0, 0,  0,  0, 0);
        tv[4]  = mk(1'b0, NOP,  1'b0, 16'h0000, 1, 0, 0, 0,  0,  0, 0);
        tv[5]  = mk(1'b0, NOP,  1'b0, 16'h0000, 0, 1, 0, 0,  0,  0, 0);
        tv[6]  = mk(1'b0, NOP,  1'b1, 16'h4000, 0, 1, 0, 0,  1,  1, 0);
        tv[7]  = mk(1'b0, NOP,  1'b1, 16'h3FFF, 0, 1, 0, 0,  2,  1, 0);
        tv[8]  = mk(1'b0, NOP,  1'b1, 16'h4001, 0, 1, 0, 0,  3,  2, 0);
        tv[9]  = mk(1'b0, NOP,  1'b1, 16'h4002, 0, 1, 0, 0,  4,  3, 0);
        tv[10] = mk(1'b0, NOP,  1'b1, 16'h4003, 0, 1, 0, 0,  5,  4, 1);
        tv[11] = mk(1'b0, NOP,  1'b1, 16'h400C, 0, 1, 0, 0,  6,  4, 0);
        tv[12] = mk(1'b0, NOP,  1'b0, 16'h4004, 0, 1, 0, 0,  7,  4, 0);
        tv[13] = mk(1'b0, NOP,  1'b1, 16'h4004, 0, 1, 0, 0,  8,  5, 0);
        tv[14] = mk(1'b0, NOP,  1'b1, 16'h4005, 0, 1, 0, 0,  9,  6, 0);
        tv[15] = mk(1'b0, NOP,  1'b1, 16'h4006, 0, 1, 0, 0, 10,  7, 0);
        tv[16] = mk(1'b0, NOP,  1'b1, 16'h4007, 0, 1, 0, 0, 11,  8, 1);
        tv[17] = mk(1'b0, NOP,  1'b1, 16'h4008, 0, 1, 0, 0, 12,  9, 0);
        tv[18] = mk(1'b0, NOP,  1'b1, 16'h4009, 0, 1, 0, 0, 13, 10, 0);
        tv[19] = mk(1'b0, NOP,  1'b1, 16'h400A, 0, 1, 0, 0, 14, 11, 0);
        tv[20] = mk(1'b0, NOP,  1'b1, 16'h400A, 1, 0, 1, 0, 15, 12, 1);
        tv[21] = mk(1'b0, NOP,  1'b1, 16'h4000, 1, 0, 1, 0, 15, 12, 0);
        tv[22] = mk(1'b0, NOP,  1'b0, 16'h0000, 1, 0, 1, 0, 15, 12, 0);

        ticks = 0;
        for (int i = 0; i < 23; i++) begin
            step(tv[i].st, tv[i].ins, tv[i].we, tv[i].ad);
            if (progress_tick === 1'b1) ticks++;
            chk_all($sformatf("v%0d", i), tv[i].e_crst, tv[i].e_run, tv[i].e_done,
                    tv[i].e_terr, tv[i].e_cyc, tv[i].e_pix, tv[i].e_tick);
        end
        chk("table.tick_count", ticks, 32'd3);

        // Halt on RUN cycle 20; start mid-RUN is ignored.
        do_start("halt");
        run_until("halt.c10", 32'd10);
        step(1'b1, NOP, 1'b0, 16'h0000);
        chk("halt.start_ignored.running", 32'(running), 32'd1);
        chk("halt.start_ignored.cycles", cycles, 32'd11);
        run_until("halt.c20", 32'd20);
        step(1'b0, HALT, 1'b0, 16'h0000);
        chk_all("halt", 1'b1, 1'b0, 1'b1, 1'b0, 32'd21, 4'd0, 1'b0);
        idle();
        chk_all("halt.frozen", 1'b1, 1'b0, 1'b1, 1'b0, 32'd21, 4'd0, 1'b0);

        // Timeout with no writes or halt.
        do_start("tmo");
        run_until("tmo.c49", 32'd49);
        chk("tmo.pre.timeout_err", 32'(timeout_err), 32'd0);
        idle();
        chk_all("tmo", 1'b1, 1'b0, 1'b0, 1'b1, 32'd50, 4'd0, 1'b0);
        idle();
        chk_all("tmo.frozen", 1'b1, 1'b0, 1'b0, 1'b1, 32'd50, 4'd0, 1'b0);

        // Halt on the timeout edge: done wins.
        do_start("tie");
        run_until("tie.c49", 32'd49);
        step(1'b0, HALT, 1'b0, 16'h0000);
        chk_all("tie", 1'b1, 1'b0, 1'b1, 1'b0, 32'd50, 4'd0, 1'b0);

        // Asynchronous reset mid-run after six writes, then a fresh run.
        do_start("rs");
        ticks = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, NOP, 1'b1, 16'(32'h4000 + i));
            if (progress_tick === 1'b1) ticks++;
        end
        chk("rs.pixels6", 32'(pixels), 32'd6);
        chk("rs.ticks", ticks, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rs.async", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
        rst = 1'b0;
        idle();
        chk_all("rs.idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0);
        do_start("rerun");
        step(1'b0, NOP, 1'b1, 16'h4005);
        chk_all("rerun.w1", 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 4'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
